// File: rtl/adc_frame_aligner.sv
// Frame-word aligner for an LTC 2-lane DDR ADC: bitslips the ISERDES until the frame lane reads
// FRAME_PATTERN, then re-interleaves lanes A/B. Define ADC_FRAME_ALIGNER_PATTERN_CHECK_EN for the test-pattern error counter.
module adc_frame_aligner #(
    parameter logic [7:0]  FRAME_PATTERN = 8'hF0,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned LOCK_COUNT    = 64,
    parameter int unsigned UNLOCK_COUNT  = 4,
    parameter int unsigned MAX_SLIPS     = 8
) (
    input  logic        sample_clk,
    input  logic        reset_n,
    input  logic [23:0] data_in,
    output logic        bitslip,
    output logic [15:0] sample,
    output logic        sample_valid,
    output logic        aligned,
    output logic [3:0]  slip_count,
    output logic        align_err,
    output logic [15:0] pattern_err_cnt,
    input  logic [15:0] test_pattern
);

    localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES);
    localparam logic [9:0] LOCK_TGT    = 10'(LOCK_COUNT);
    localparam logic [3:0] UNLOCK_TGT  = 4'(UNLOCK_COUNT);
    localparam logic [3:0] SLIP_TGT    = 4'(MAX_SLIPS);

    typedef enum logic [1:0] {
        ST_SETTLE,
        ST_CHECK,
        ST_SLIP,
        ST_LOCKED
    } state_t;

    state_t      state_q;
    logic [7:0]  settle_q;
    logic [9:0]  match_q;
    logic [9:0]  match_d;
    logic [3:0]  unlock_q;
    logic [3:0]  unlock_d;
    logic [3:0]  slip_q;
    logic [3:0]  slip_d;
    logic        bitslip_q;
    logic        aligned_q;
    logic        align_err_q;
    logic        sample_valid_q;
    logic [15:0] sample_q;
    logic [15:0] sample_d;
    logic        frame_ok;
    logic        unlock_evt;

    assign frame_ok   = (data_in[23:16] == FRAME_PATTERN);
    assign match_d    = match_q + 10'd1;
    assign unlock_d   = unlock_q + 4'd1;
    assign slip_d     = slip_q + 4'd1;
    assign unlock_evt = (state_q == ST_LOCKED) && !frame_ok && (unlock_d == UNLOCK_TGT);

    // Bit 7 of each lane arrives first, so A/B pairs interleave MSB-first with A leading.
    assign sample_d = {data_in[7],  data_in[15], data_in[6],  data_in[14],
                       data_in[5],  data_in[13], data_in[4],  data_in[12],
                       data_in[3],  data_in[11], data_in[2],  data_in[10],
                       data_in[1],  data_in[9],  data_in[0],  data_in[8]};

    always_ff @(posedge sample_clk) begin
        if (!reset_n) begin
            state_q        <= ST_SETTLE;
            settle_q       <= SETTLE_INIT;
            match_q        <= '0;
            unlock_q       <= '0;
            slip_q         <= '0;
            bitslip_q      <= 1'b0;
            aligned_q      <= 1'b0;
            align_err_q    <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_q       <= '0;
        end else begin
            bitslip_q      <= 1'b0;
            sample_q       <= sample_d;
            sample_valid_q <= aligned_q && frame_ok;
            case (state_q)
                ST_SETTLE: begin
                    if (settle_q == 8'd0) begin
                        state_q <= ST_CHECK;
                    end else begin
                        settle_q <= settle_q - 8'd1;
                    end
                end
                ST_CHECK: begin
                    if (frame_ok) begin
                        match_q <= match_d;
                        if (match_d == LOCK_TGT) begin
                            state_q   <= ST_LOCKED;
                            aligned_q <= 1'b1;
                            unlock_q  <= '0;
                        end
                    end else begin
                        match_q <= '0;
                        state_q <= ST_SLIP;
                    end
                end
                ST_SLIP: begin
                    // Slip counter wraps so the search keeps cycling; align_err stays sticky.
                    bitslip_q <= 1'b1;
                    settle_q  <= SETTLE_INIT;
                    state_q   <= ST_SETTLE;
                    if (slip_d == SLIP_TGT) begin
                        align_err_q <= 1'b1;
                        slip_q      <= '0;
                    end else begin
                        slip_q <= slip_d;
                    end
                end
                ST_LOCKED: begin
                    if (frame_ok) begin
                        unlock_q <= '0;
                    end else if (unlock_evt) begin
                        aligned_q <= 1'b0;
                        match_q   <= '0;
                        unlock_q  <= '0;
                        state_q   <= ST_SLIP;
                    end else begin
                        unlock_q <= unlock_d;
                    end
                end
                default: begin
                    state_q <= ST_SETTLE;
                end
            endcase
        end
    end

    assign bitslip      = bitslip_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign aligned      = aligned_q;
    assign slip_count   = slip_q;
    assign align_err    = align_err_q;

`ifdef ADC_FRAME_ALIGNER_PATTERN_CHECK_EN
    logic [15:0] perr_q;

    // Counts valid samples that differ from the ADC test pattern; restarts on every loss of lock.
    always_ff @(posedge sample_clk) begin
        if (!reset_n) begin
            perr_q <= '0;
        end else if (unlock_evt) begin
            perr_q <= '0;
        end else if (sample_valid_q && (sample_q != test_pattern) && (perr_q != 16'hFFFF)) begin
            perr_q <= perr_q + 16'd1;
        end
    end

    assign pattern_err_cnt = perr_q;
`else
    logic unused_test_pattern;
    assign unused_test_pattern = ^test_pattern;
    assign pattern_err_cnt     = 16'h0000;
`endif

endmodule

// File: tb/tb_adc_frame_aligner.sv
// Bench for adc_frame_aligner: deserializer model that rotates the frame word on bitslip,
// a cycle-timeline reference model compared every cycle, and directed plus random stimulus.
module tb_adc_frame_aligner;

    localparam int         SETTLE  = 16;
    localparam int         LOCKN   = 64;
    localparam int         UNLOCKN = 4;
    localparam int         MAXS    = 8;
    localparam logic [7:0] PAT     = 8'hF0;

    logic        sample_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [23:0] data_in = '0;
    logic [15:0] test_pattern = 16'h000D;
    logic        bitslip;
    logic [15:0] sample;
    logic        sample_valid;
    logic        aligned;
    logic [3:0]  slip_count;
    logic        align_err;
    logic [15:0] pattern_err_cnt;

    adc_frame_aligner dut (
        .sample_clk      (sample_clk),
        .reset_n         (reset_n),
        .data_in         (data_in),
        .bitslip         (bitslip),
        .sample          (sample),
        .sample_valid    (sample_valid),
        .aligned         (aligned),
        .slip_count      (slip_count),
        .align_err       (align_err),
        .pattern_err_cnt (pattern_err_cnt),
        .test_pattern    (test_pattern)
    );

    always #5 sample_clk = ~sample_clk;

    int checks = 0;
    int failures = 0;

    // Reference model: absolute cycle timeline of compares and slips.
    logic        m_init = 1'b0;
    logic        m_bitslip = 1'b0;
    logic [15:0] m_sample = '0;
    logic        m_valid = 1'b0;
    logic        m_aligned = 1'b0;
    int          m_slips = 0;
    logic        m_err = 1'b0;
    int          m_perr = 0;
    int          c = 0;
    int          next_check = -1;
    int          slip_at = -1;
    int          run = 0;
    int          misses = 0;

    function automatic logic [15:0] weave(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[i] = (i % 2 == 1) ? a[i/2] : b[i/2];
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < (n % 8); i++) begin
            r = {r[6:0], r[7]};
        end
        return r;
    endfunction

    always @(posedge sample_clk) begin : model
        logic [7:0]  fr;
        logic        prev_valid;
        logic [15:0] prev_sample;
        logic        unlock_now;
        fr          = data_in[23:16];
        prev_valid  = m_valid;
        prev_sample = m_sample;
        unlock_now  = 1'b0;
        if (!reset_n) begin
            m_init = 1'b1; m_bitslip = 1'b0; m_sample = '0; m_valid = 1'b0;
            m_aligned = 1'b0; m_slips = 0; m_err = 1'b0; m_perr = 0;
            c = 0; next_check = SETTLE + 2; slip_at = -1; run = 0; misses = 0;
        end else begin
            m_valid   = m_aligned && (fr == PAT);
            m_sample  = weave(data_in[7:0], data_in[15:8]);
            m_bitslip = 1'b0;
            c++;
            if (m_aligned) begin
                if (fr == PAT) begin
                    misses = 0;
                end else begin
                    misses++;
                    if (misses == UNLOCKN) begin
                        m_aligned = 1'b0; misses = 0; run = 0; slip_at = c + 1; unlock_now = 1'b1;
                    end
                end
            end else if (c == slip_at) begin
                m_bitslip = 1'b1;
                m_slips++;
                if (m_slips == MAXS) begin
                    m_err = 1'b1; m_slips = 0;
                end
                next_check = c + SETTLE + 2;
                slip_at = -1;
            end else if (next_check >= 0 && c >= next_check) begin
                if (fr == PAT) begin
                    run++;
                    if (run == LOCKN) m_aligned = 1'b1;
                end else begin
                    run = 0; next_check = -1; slip_at = c + 1;
                end
            end
`ifdef ADC_FRAME_ALIGNER_PATTERN_CHECK_EN
            if (unlock_now) m_perr = 0;
            else if (prev_valid && (prev_sample != test_pattern) && (m_perr < 65535)) m_perr++;
`endif
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
            if (failures >= 200) begin
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    endtask

    // Deserializer model state and stimulus bookkeeping.
    logic [7:0] frame_base = PAT;
    int         rot = 0;
    logic       ovr_en = 1'b0;
    logic [7:0] ovr_val = '0;
    logic [7:0] la = 8'h02;
    logic [7:0] lb = 8'h03;
    int         cyc = 0;
    int         pulses = 0;
    int         last_pulse = -1;
    int         min_gap = 1000;

    task automatic drive();
        data_in = {(ovr_en ? ovr_val : rotl8(frame_base, rot)), lb, la};
    endtask

    task automatic step();
        @(negedge sample_clk);
        if (m_init) begin
            chk("cyc_bitslip", int'(bitslip), int'(m_bitslip));
            chk("cyc_sample", int'(sample), int'(m_sample));
            chk("cyc_sample_valid", int'(sample_valid), int'(m_valid));
            chk("cyc_aligned", int'(aligned), int'(m_aligned));
            chk("cyc_slip_count", int'(slip_count), m_slips);
            chk("cyc_align_err", int'(align_err), int'(m_err));
            chk("cyc_pattern_err_cnt", int'(pattern_err_cnt), m_perr);
        end
        #1;
        cyc++;
        if (bitslip) begin
            pulses++;
            if (last_pulse >= 0 && (cyc - last_pulse - 1) < min_gap) min_gap = cyc - last_pulse - 1;
            last_pulse = cyc;
            rot++;
        end
        drive();
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        drive();
        repeat (n) step();
        chk("rst_bitslip", int'(bitslip), 0);
        chk("rst_sample", int'(sample), 0);
        chk("rst_sample_valid", int'(sample_valid), 0);
        chk("rst_aligned", int'(aligned), 0);
        chk("rst_slip_count", int'(slip_count), 0);
        chk("rst_align_err", int'(align_err), 0);
        chk("rst_pattern_err_cnt", int'(pattern_err_cnt), 0);
        reset_n = 1'b1;
        rot = 0; pulses = 0; last_pulse = -1; min_gap = 1000;
        drive();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int burst;
        burst = 0;
        drive();

        // Frame already aligned: lock with no slips.
        frame_base = PAT;
        do_reset(3);
        n = 0;
        while (!aligned && n < 500) begin
            step();
            n++;
        end
        chk("t1_lock_latency", n, SETTLE + LOCKN + 1);
        chk("t1_no_pulses", pulses, 0);
        chk("t1_slip_count", int'(slip_count), 0);

        // Interleave and per-word validity.
        step();
        chk("t3_sample", int'(sample), 16'h000D);
        chk("t3_valid", int'(sample_valid), 1);
        ovr_en = 1'b1; ovr_val = 8'hE1; drive();
        step();
        ovr_en = 1'b0; drive();
        chk("t3_mismatch_invalid", int'(sample_valid), 0);
        chk("t3_still_aligned", int'(aligned), 1);

        // Test-pattern error counter.
        step();
        la = 8'h02; lb = 8'h02; drive();
        repeat (10) step();
        la = 8'h02; lb = 8'h03; drive();
        step();
        step();
`ifdef ADC_FRAME_ALIGNER_PATTERN_CHECK_EN
        chk("t6_perr_count", int'(pattern_err_cnt), 10);
`else
        chk("t6_perr_off", int'(pattern_err_cnt), 0);
`endif

        // Unlock hysteresis.
        ovr_en = 1'b1; ovr_val = 8'hE1; drive();
        repeat (3) step();
        ovr_en = 1'b0; drive();
        step();
        chk("t4_three_misses_hold", int'(aligned), 1);
        ovr_en = 1'b1; drive();
        repeat (4) step();
        ovr_en = 1'b0; drive();
        chk("t4_unlocked", int'(aligned), 0);
        chk("t4_no_pulse_yet", int'(bitslip), 0);
        chk("t4_perr_cleared", int'(pattern_err_cnt), 0);
        step();
        chk("t4_pulse", int'(bitslip), 1);
        chk("t4_slip_count", int'(slip_count), 1);

        // Rotating frame word needs three slips.
        frame_base = 8'h1E;
        do_reset(2);
        n = 0;
        while (!aligned && n < 3000) begin
            step();
            n++;
        end
        chk("t2_aligned", int'(aligned), 1);
        chk("t2_pulses", pulses, 3);
        chk("t2_slip_count", int'(slip_count), 3);
        chk("t2_min_gap_ge17", int'(min_gap >= SETTLE + 1), 1);

        // Stuck frame lane: sticky error and wrapping slip counter.
        frame_base = 8'h00;
        do_reset(2);
        n = 0;
        while (!align_err && n < 3000) begin
            step();
            n++;
        end
        chk("t5_align_err", int'(align_err), 1);
        chk("t5_pulses_at_err", pulses, MAXS);
        chk("t5_slip_wrap", int'(slip_count), 0);
        repeat (60) step();
        chk("t5_keeps_slipping", int'(pulses > MAXS), 1);
        chk("t5_err_sticky", int'(align_err), 1);
        do_reset(1);

        // Random phase against the reference model.
        frame_base = rotl8(PAT, $urandom_range(0, 7));
        do_reset(1);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 1499) == 0) begin
                reset_n = 1'b0;
                rot = 0;
                frame_base = rotl8(PAT, $urandom_range(0, 7));
            end else begin
                reset_n = 1'b1;
            end
            la = 8'($urandom_range(2, 3));
            lb = 8'($urandom_range(2, 3));
            if (burst == 0 && $urandom_range(0, 199) == 0) burst = $urandom_range(1, 6);
            if (burst > 0) begin
                ovr_en = 1'b1;
                ovr_val = 8'($urandom_range(0, 255));
                burst--;
            end else begin
                ovr_en = 1'b0;
            end
            if ($urandom_range(0, 999) == 0) test_pattern = {12'h000, 4'($urandom_range(12, 15))};
            drive();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_frame_aligner.md
Name: adc_frame_aligner

Overview:
- Sits directly downstream of the 8:1 ISERDES data deserializer (3 lanes: frame, B, A) in the LTC 2-lane DDR ADC receive path.
- Runs on the deserializer's parallel sample clock and monitors the deserialized frame-clock word.
- Issues single-cycle bitslip pulses back to the deserializer until that word equals the expected pattern.
- Once locked, re-interleaves lanes A/B into 16-bit ADC samples with a valid/aligned indication.

Parameters:
- FRAME_PATTERN, 8'hF0, expected frame lane word when aligned.
- SETTLE_CYCLES, 16, sample_clk cycles to wait after each bitslip pulse before checking the frame word (width 8 bits; legal range 1..255).
- LOCK_COUNT, 64, consecutive matching frame words required to declare lock (legal range 1..1023).
- UNLOCK_COUNT, 4, consecutive mismatching frame words in LOCKED that drop lock (legal range 1..15).
- MAX_SLIPS, 8, bitslips attempted before error is flagged and the slip counter restarts.

Ports:
- sample_clk  in  1  parallel-word clock from the deserializer clock PLL (x1 output).
- reset_n  in  1  synchronous, active-low reset.
- data_in  in  24  deserializer word {frame[23:16], lane_b[15:8], lane_a[7:0]}; bit 7 of each lane is the first bit received.
- bitslip  out  1  one-cycle pulse to deserializer bitslip input.
- sample  out  16  reconstructed ADC sample.
- sample_valid  out  1  high when sample is from an aligned word.
- aligned  out  1  high in LOCKED.
- slip_count  out  4  bitslips issued in the current attempt.
- align_err  out  1  sticky; set when MAX_SLIPS is reached without lock; cleared only by reset.
- pattern_err_cnt  out  16  see Optional Feature.
- test_pattern  in  16  see Optional Feature.

Behaviour:
- Reset (reset_n=0 at a sample_clk edge): all outputs 0; state=SETTLE; settle counter=SETTLE_CYCLES; match counter=0.
- SETTLE: decrement the settle counter each cycle; at 0 go to CHECK.
- CHECK: compare data_in[23:16] with FRAME_PATTERN.
  - Match: increment the match counter. At LOCK_COUNT go to LOCKED and set aligned=1 on the next cycle.
  - Mismatch: clear the match counter and go to SLIP.
- SLIP: bitslip=1 for exactly one cycle and slip_count increments.
  - If the new slip_count == MAX_SLIPS: set align_err and reset slip_count to 0.
  - Then reload the settle counter and go to SETTLE.
  - Consecutive bitslip pulses are always separated by at least SETTLE_CYCLES+1 low cycles.
- LOCKED:
  - Each mismatch increments the unlock counter; any match clears it.
  - When the unlock counter reaches UNLOCK_COUNT: clear aligned, clear the match counter, then go to SLIP.
- Sample reconstruction, for k=0..7:
  - sample[15-2k] = lane_a[7-k]
  - sample[14-2k] = lane_b[7-k]
  - Registered: word at edge n appears on sample at edge n+1, so latency is 1 cycle.
- sample_valid:
  - Equals aligned registered alongside sample.
  - Is 0 for a word whose frame mismatched, even while LOCKED.
- sample updates every cycle regardless of state; consumers gate on sample_valid.
- Reset asserted mid-SLIP or mid-SETTLE aborts immediately; bitslip is 0 in the reset cycle.

Optional Feature:
- Macro: ADC_FRAME_ALIGNER_PATTERN_CHECK_EN.
- With the macro: on each cycle with sample_valid=1 and sample != test_pattern, pattern_err_cnt increments, saturating at 16'hFFFF. It is cleared by reset and by any transition out of LOCKED.
- Without the macro: pattern_err_cnt is constant 0, test_pattern is ignored, and no comparator logic is built.

Test Plan:
1. Frame lane constant 8'hF0 from reset release -> no bitslip pulse; aligned=1 exactly SETTLE_CYCLES+LOCK_COUNT+1 cycles after reset release; slip_count=0.
2. Deserializer model rotates frame word by one bit per bitslip; start at 8'h1E -> exactly 3 bitslip pulses, each separated by at least 17 cycles (defaults); then aligned=1 and slip_count=3.
3. Aligned, with lane_a=8'h02 and lane_b=8'h03 -> sample=16'h000D one cycle later, sample_valid=1. Same word with frame 8'hE1 -> sample_valid=0 for that word.
4. In LOCKED, inject 3 mismatching frame words then 1 match -> aligned stays 1. Inject 4 consecutive mismatches -> aligned=0 and one bitslip pulse on the next cycle.
5. Frame lane stuck at 8'h00 -> align_err goes high after the 8th pulse; slip_count wraps to 0 and slipping continues; reset_n=0 for one cycle clears align_err and all outputs.
6. Macro defined, test_pattern=16'h000D, locked: 10 samples of 16'h000C -> pattern_err_cnt=10. Unlock event -> pattern_err_cnt=0. Macro undefined -> pattern_err_cnt stays 0.
